shift_normalizer: RTL and testbench



---
 rtl/shift_normalizer.sv | 93 +++++++++
 tb/tb_shift_normalizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// Sequential left-normalizer: shifts an accepted 8-bit operand left one bit per clock until normalized.
// Define SHIFT_NORM_ARITH_EN to compile in sign-normalize mode selected per operand by in_arith.
//
// state   | meaning
// S_IDLE  | waiting for an operand, in_ready high
// S_SHIFT | shifting working register until the stop condition holds
// S_DONE  | result presented, held until out_ready
module shift_normalizer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_arith,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_n,
  output logic       out_zero,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_w;
  logic [3:0] r_cnt;
  logic       r_zero;
  logic       w_stop;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef SHIFT_NORM_ARITH_EN
  logic r_arith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_arith <= 1'b0;
    else if (w_accept)
      r_arith <= in_arith;
  end

  // Sign-normalize stops one short of full width: the sign bit itself must survive.
  assign w_stop = r_arith ? ((r_w[7] ^ r_w[6]) || (r_cnt == 4'd7))
                          : (r_w[7] || (r_cnt == 4'd8));
`else
  logic w_unused;
  assign w_unused = in_arith;
  assign w_stop   = r_w[7] || (r_cnt == 4'd8);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_stop) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w    <= 8'h00;
      r_cnt  <= 4'd0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_w    <= in_data;
      r_cnt  <= 4'd0;
      r_zero <= (in_data == 8'h00);
    end else if ((r_state == S_SHIFT) && !w_stop) begin
      r_w    <= {r_w[6:0], 1'b0};
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_w;
  assign out_n     = r_cnt;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: driver pushes expected results, negedge monitor pops on handshake.
// Expectations for in_arith follow whether SHIFT_NORM_ARITH_EN is defined for this build.
module tb_shift_normalizer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_arith = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_n;
  logic       out_zero;
  logic       busy;

`ifdef SHIFT_NORM_ARITH_EN
  localparam bit ARITH_ON = 1'b1;
`else
  localparam bit ARITH_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] n;
    logic       zero;
    logic       logical;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  logic prev_valid = 1'b0;

  shift_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_n(out_n), .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference count: leading zeros (logical) or redundant sign bits capped at 7 (arith).
  function automatic logic [3:0] model_n(input logic [7:0] d, input logic ar);
    int k = 0;
    if (!ar) begin
      while (k < 8 && d[7-k] == 1'b0) k++;
    end else begin
      while (k < 7 && d[6-k] == d[7]) k++;
    end
    return 4'(k);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) first_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_n", out_n, e.n);
          check("out_zero", out_zero, e.zero);
          check("latency", first_cyc - e.acc, e.n + 2);
          if (e.logical && !e.zero) check("msb_set", out_data[7], 1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic ar, input logic [7:0] ed, input logic [3:0] en);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_arith = ar;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.data    = ed;
    e.n       = en;
    e.zero    = (d == 8'h00);
    e.logical = !(ar && ARITH_ON);
    e.acc     = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((q.size() != 0 || busy) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    logic [7:0] hold_data;
    logic [3:0] hold_n;
    logic       hold_zero;
    int         waited;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_n", out_n, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Logical directed vectors
    send(8'h80, 1'b0, 8'h80, 4'd0);
    send(8'h05, 1'b0, 8'hA0, 4'd5);
    send(8'h00, 1'b0, 8'h00, 4'd8);
    send(8'h01, 1'b0, 8'h80, 4'd7);

    // in_arith vectors: sign-normalize when compiled in, otherwise logical
    if (ARITH_ON) begin
      send(8'hFF, 1'b1, 8'h80, 4'd7);
      send(8'h30, 1'b1, 8'h60, 4'd1);
      send(8'hC0, 1'b1, 8'h80, 4'd1);
      send(8'hF0, 1'b1, 8'h80, 4'd3);
      send(8'h00, 1'b1, 8'h00, 4'd7);
    end else begin
      send(8'hFF, 1'b1, 8'hFF, 4'd0);
      send(8'h30, 1'b1, 8'hC0, 4'd2);
      send(8'hC0, 1'b1, 8'hC0, 4'd0);
      send(8'hF0, 1'b1, 8'hF0, 4'd0);
      send(8'h00, 1'b1, 8'h00, 4'd8);
    end
    drain();

    // Backpressure: result must hold and new operands must be ignored
    out_ready = 1'b0;
    send(8'h05, 1'b0, 8'hA0, 4'd5);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("bp_valid_seen", out_valid, 1);
    hold_data = out_data;
    hold_n    = out_n;
    hold_zero = out_zero;
    in_valid  = 1'b1;
    in_data   = 8'h80;
    in_arith  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_data_hold", out_data, hold_data);
      check("bp_n_hold", out_n, hold_n);
      check("bp_zero_hold", out_zero, hold_zero);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_busy_after", busy, 0);
    check("bp_single_transfer", q.size(), 0);

    // Reset in the middle of shifting 8'h01
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_arith = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_n", out_n, 0);
    check("mid_rst_out_zero", out_zero, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h40, 1'b0, 8'h80, 4'd1);
    drain();

    // Sweep of every operand in both modes against the reference count
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        logic [7:0] d;
        logic [3:0] en;
        d  = 8'(v);
        en = model_n(d, (m == 1) && ARITH_ON);
        send(d, m[0], 8'(d << en), en);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
